testpattern_checker: RTL and testbench

- Receiver-side counterpart of the PPU test pattern generator.
- Consumes the pattern-bearing video stream (sync + RGB), tracks line/frame position from the embedded syncs, and predicts the expected checkerboard pattern.
- Compares each valid sample against that prediction and reports lock, per-frame pass/fail, error counts and measured frame geometry.
- Sits after the pattern generator, or at the end of the PPU chain, for bring-up and regression.

---
 rtl/testpattern_checker.sv | 181 ++++++++++++++++++
 tb/tb_testpattern_checker.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testpattern_checker.sv
// rtl/testpattern_checker.sv - receiver-side checker for the checkerboard test pattern stream
// Optional first-error log ports: define TESTPATTERN_CHECKER_ERRLOG_EN.
module testpattern_checker #(
  parameter int         COLOR_W     = 7,
  parameter logic [8:0] VSTART_NTSC = 9'd16,
  parameter logic [8:0] VSTOP_NTSC  = 9'd256,
  parameter logic [8:0] VSTART_PAL  = 9'd20,
  parameter logic [8:0] VSTOP_PAL   = 9'd308,
  parameter logic [9:0] HSTART_NTSC = 10'd64,
  parameter logic [9:0] HSTOP_NTSC  = 10'd704,
  parameter logic [9:0] HSTART_PAL  = 10'd64,
  parameter logic [9:0] HSTOP_PAL   = 10'd704
) (
  input  logic                   VCLK,
  input  logic                   RST,
  input  logic                   palmode,
  input  logic                   vdata_valid_i,
  input  logic [4+3*COLOR_W-1:0] vdata_i,
  output logic                   locked_o,
  output logic                   frame_done_o,
  output logic                   frame_pass_o,
  output logic [15:0]            err_cnt_o,
  output logic [15:0]            frame_cnt_o,
  output logic [8:0]             vtotal_o,
  output logic [9:0]             htotal_o
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
  ,
  output logic [9:0]             first_err_h_o,
  output logic [8:0]             first_err_v_o,
  output logic                   first_err_valid_o
`endif
);

  localparam int CW = 3 * COLOR_W;
  localparam int DW = 4 + CW;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ALIGN    = 2'd1,
    S_CHECK    = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_prev_sync;
  logic [9:0]  r_h;
  logic [8:0]  r_v;
  logic        r_e;
  logic [8:0]  r_ref_vtotal;
  logic        r_frame_err;

  logic [3:0]    w_sync;
  logic [CW-1:0] w_color;
  logic          w_vs_fall;
  logic          w_hs_fall;
  logic          w_in_v;
  logic          w_mismatch;
  logic          w_sync_unused;
  logic [8:0]    w_vstart;
  logic [8:0]    w_vstop;
  logic [8:0]    w_v_inc;
  logic [9:0]    w_hstart;
  logic [9:0]    w_hstop;
  logic [9:0]    w_h_inc;
  logic [15:0]   w_err_inc;

  // Sync nibble is {nVSYNC, nCLAMP, nHSYNC, nCSYNC}; only V and H edges drive timing.
  assign w_sync        = vdata_i[DW-1 -: 4];
  assign w_color       = vdata_i[CW-1:0];
  assign w_vs_fall     = r_prev_sync[3] & ~w_sync[3];
  assign w_hs_fall     = r_prev_sync[1] & ~w_sync[1];
  assign w_sync_unused = r_prev_sync[2] ^ r_prev_sync[0];

  assign w_vstart = palmode ? VSTART_PAL : VSTART_NTSC;
  assign w_vstop  = palmode ? VSTOP_PAL  : VSTOP_NTSC;
  assign w_hstart = palmode ? HSTART_PAL : HSTART_NTSC;
  assign w_hstop  = palmode ? HSTOP_PAL  : HSTOP_NTSC;

  assign w_in_v     = (r_v >= w_vstart) && (r_v < w_vstop);
  assign w_mismatch = (w_color != {CW{r_e}});
  assign w_v_inc    = (r_v == 9'd511) ? r_v : r_v + 9'd1;
  assign w_h_inc    = (r_h == 10'd1023) ? r_h : r_h + 10'd1;
  assign w_err_inc  = (err_cnt_o == 16'hFFFF) ? err_cnt_o : err_cnt_o + 16'd1;

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_UNLOCKED;
      r_prev_sync  <= 4'hF;
      r_h          <= '0;
      r_v          <= '0;
      r_e          <= 1'b0;
      r_ref_vtotal <= '0;
      r_frame_err  <= 1'b0;
      locked_o     <= 1'b0;
      frame_done_o <= 1'b0;
      frame_pass_o <= 1'b0;
      err_cnt_o    <= '0;
      frame_cnt_o  <= '0;
      vtotal_o     <= '0;
      htotal_o     <= '0;
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
      first_err_h_o     <= '0;
      first_err_v_o     <= '0;
      first_err_valid_o <= 1'b0;
`endif
    end else begin
      frame_done_o <= 1'b0;
      if (vdata_valid_i) begin
        r_prev_sync <= w_sync;

        if (w_hs_fall) begin
          htotal_o <= r_h;
          r_h      <= '0;
          r_v      <= w_v_inc;
        end else begin
          r_h <= w_h_inc;
        end
        if (w_vs_fall) begin
          r_v      <= '0;
          vtotal_o <= r_v;
        end

        // Prediction for the next valid sample; checker phase restarts on each line from v[0].
        if (w_in_v && (r_h == w_hstart)) begin
          r_e <= r_v[0];
        end else if (w_in_v && (r_h > w_hstart) && (r_h < w_hstop)) begin
          r_e <= ~r_e;
        end else begin
          r_e <= 1'b0;
        end

        case (r_state)
          S_UNLOCKED: begin
            if (w_vs_fall) begin
              r_state <= S_ALIGN;
            end
          end
          S_ALIGN: begin
            if (w_vs_fall) begin
              r_state      <= S_CHECK;
              r_ref_vtotal <= r_v;
              err_cnt_o    <= '0;
              r_frame_err  <= 1'b0;
              locked_o     <= 1'b1;
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
              first_err_h_o     <= '0;
              first_err_v_o     <= '0;
              first_err_valid_o <= 1'b0;
`endif
            end
          end
          S_CHECK: begin
            if (w_mismatch) begin
              err_cnt_o   <= w_err_inc;
              r_frame_err <= 1'b1;
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
              if (!first_err_valid_o) begin
                first_err_h_o     <= r_h;
                first_err_v_o     <= r_v;
                first_err_valid_o <= 1'b1;
              end
`endif
            end
            // An error on the boundary sample still belongs to the frame being closed.
            if (w_vs_fall) begin
              frame_done_o <= 1'b1;
              frame_pass_o <= ~(r_frame_err | w_mismatch);
              frame_cnt_o  <= frame_cnt_o + 16'd1;
              r_frame_err  <= 1'b0;
              if (r_v != r_ref_vtotal) begin
                r_state  <= S_UNLOCKED;
                locked_o <= 1'b0;
              end
            end
          end
          default: r_state <= S_UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_testpattern_checker.sv
// tb/tb_testpattern_checker.sv - randomized scoreboard bench for testpattern_checker
// Small window parameters keep frames short; frame_done results are checked by a forked monitor.
module tb_testpattern_checker;

  localparam int COLOR_W = 7;
  localparam int CW      = 3 * COLOR_W;
  localparam int DW      = 4 + CW;
  localparam int L       = 24;
  localparam int N       = 14;
  localparam int VS_N = 3, VE_N = 11, HS_N = 4, HE_N = 18;
  localparam int VS_P = 2, VE_P = 12, HS_P = 5, HE_P = 20;

  logic          VCLK          = 1'b0;
  logic          RST           = 1'b1;
  logic          palmode       = 1'b0;
  logic          vdata_valid_i = 1'b0;
  logic [DW-1:0] vdata_i       = {4'hF, {CW{1'b0}}};
  logic          locked_o;
  logic          frame_done_o;
  logic          frame_pass_o;
  logic [15:0]   err_cnt_o;
  logic [15:0]   frame_cnt_o;
  logic [8:0]    vtotal_o;
  logic [9:0]    htotal_o;
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
  logic [9:0]    first_err_h_o;
  logic [8:0]    first_err_v_o;
  logic          first_err_valid_o;
`endif

  testpattern_checker #(
    .COLOR_W    (COLOR_W),
    .VSTART_NTSC(9'(VS_N)),  .VSTOP_NTSC(9'(VE_N)),
    .VSTART_PAL (9'(VS_P)),  .VSTOP_PAL (9'(VE_P)),
    .HSTART_NTSC(10'(HS_N)), .HSTOP_NTSC(10'(HE_N)),
    .HSTART_PAL (10'(HS_P)), .HSTOP_PAL (10'(HE_P))
  ) dut (
    .VCLK         (VCLK),
    .RST          (RST),
    .palmode      (palmode),
    .vdata_valid_i(vdata_valid_i),
    .vdata_i      (vdata_i),
    .locked_o     (locked_o),
    .frame_done_o (frame_done_o),
    .frame_pass_o (frame_pass_o),
    .err_cnt_o    (err_cnt_o),
    .frame_cnt_o  (frame_cnt_o),
    .vtotal_o     (vtotal_o),
    .htotal_o     (htotal_o)
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
    ,
    .first_err_h_o    (first_err_h_o),
    .first_err_v_o    (first_err_v_o),
    .first_err_valid_o(first_err_valid_o)
`endif
  );

  always #5 VCLK = ~VCLK;

  typedef struct packed {
    logic        pass;
    logic [15:0] err;
    logic [15:0] fcnt;
    logic [8:0]  vt;
    logic        locked;
  } exp_t;

  exp_t sb_q[$];
  exp_t mx;

  int n_checks = 0;
  int n_errors = 0;

  int m_state, m_ref, m_err, m_fcnt, m_prev_lines, m_fe_h, m_fe_v;
  bit m_ferr, m_locked, m_edge_sent, m_fe_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_err = 0; m_fcnt = 0; m_prev_lines = 1;
    m_ferr = 0; m_locked = 0; m_edge_sent = 0;
    m_fe_valid = 0; m_fe_h = 0; m_fe_v = 0;
  endtask

  // Colour bit carried by sample (line i, sample j) of a frame whose line 0 sample 0 holds both
  // sync edges: samples j>=2 show pixel h=j-2, with one-pixel checker phase set by the line number.
  function automatic logic exp_bit(input int i, input int j, input bit pal);
    int vs, ve, hs, he, h;
    vs = pal ? VS_P : VS_N;
    ve = pal ? VE_P : VE_N;
    hs = pal ? HS_P : HS_N;
    he = pal ? HE_P : HE_N;
    if (j < 2) return 1'b0;
    h = j - 2;
    if (i >= vs && i < ve && h >= hs && h < he) return 1'((i + h - hs) % 2);
    return 1'b0;
  endfunction

  task automatic drive_sample(input int i, input int j, input bit spal, input bit inv,
                              input bit flip, input int vprob);
    logic          d, e;
    logic [CW-1:0] col;
    logic [3:0]    sy;
    exp_t          x;
    while ($urandom_range(99) < vprob) begin
      @(posedge VCLK); #1;
      vdata_valid_i = 1'b0;
      vdata_i       = DW'($urandom);
    end
    d   = exp_bit(i, j, spal) ^ inv;
    col = {CW{d}};
    if (flip) col[0] = ~col[0];
    e   = exp_bit(i, j, palmode);
    sy  = {1'(i >= 2), 1'b1, 1'(j >= 3), 1'((i >= 2) && (j >= 3))};

    if (m_state == 2 && col != {CW{e}}) begin
      if (m_err < 65535) m_err++;
      m_ferr = 1;
      if (!m_fe_valid) begin
        m_fe_valid = 1;
        m_fe_h = (j == 0) ? L - 1 : j - 1;
        m_fe_v = (j == 0) ? ((i == 0) ? m_prev_lines - 1 : i - 1) : i;
      end
    end
    if (i == 0 && j == 0) begin
      case (m_state)
        0: m_state = 1;
        1: begin
          m_state = 2; m_ref = m_prev_lines - 1; m_err = 0; m_ferr = 0; m_locked = 1;
          m_fe_valid = 0; m_fe_h = 0; m_fe_v = 0;
        end
        default: begin
          m_fcnt = (m_fcnt + 1) % 65536;
          if (m_prev_lines - 1 != m_ref) begin
            m_state  = 0;
            m_locked = 0;
          end
          x.pass   = !m_ferr;
          x.err    = 16'(m_err);
          x.fcnt   = 16'(m_fcnt);
          x.vt     = 9'(m_prev_lines - 1);
          x.locked = m_locked;
          sb_q.push_back(x);
          m_ferr = 0;
        end
      endcase
    end

    @(posedge VCLK); #1;
    vdata_valid_i = 1'b1;
    vdata_i       = {sy, col};
  endtask

  task automatic settle();
    @(posedge VCLK); #1;
    vdata_valid_i = 1'b0;
    @(negedge VCLK);
  endtask

  task automatic send_frame(input int nlines, input bit spal, input bit inv,
                            input int fi, input int fj, input int vprob);
    for (int i = 0; i < nlines; i++) begin
      for (int j = 0; j < L; j++) begin
        if (i == 0 && j == 0 && m_edge_sent) begin
          m_edge_sent = 0;
          continue;
        end
        drive_sample(i, j, spal, inv, (i == fi && j == fj), vprob);
      end
    end
    m_prev_lines = nlines;
  endtask

  task automatic drive_edge(input bit spal, input bit inv);
    drive_sample(0, 0, spal, inv, 1'b0, 0);
    m_edge_sent = 1;
    settle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},     32'(locked_o),     0);
    check({tag, "_frame_done"}, 32'(frame_done_o), 0);
    check({tag, "_frame_pass"}, 32'(frame_pass_o), 0);
    check({tag, "_err_cnt"},    32'(err_cnt_o),    0);
    check({tag, "_frame_cnt"},  32'(frame_cnt_o),  0);
    check({tag, "_vtotal"},     32'(vtotal_o),     0);
    check({tag, "_htotal"},     32'(htotal_o),     0);
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
    check({tag, "_fe_valid"},   32'(first_err_valid_o), 0);
`endif
  endtask

  task automatic check_errlog(input string tag);
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
    check({tag, "_fe_valid"}, 32'(first_err_valid_o), 32'(m_fe_valid));
    check({tag, "_fe_h"},     32'(first_err_h_o),     32'(m_fe_h));
    check({tag, "_fe_v"},     32'(first_err_v_o),     32'(m_fe_v));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    model_reset();
    fork
      forever begin
        @(negedge VCLK);
        if (frame_done_o === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_done_unexpected: got strobe expected none");
          end else begin
            mx = sb_q.pop_front();
            check("sb_frame_pass", 32'(frame_pass_o), 32'(mx.pass));
            check("sb_err_cnt",    32'(err_cnt_o),    32'(mx.err));
            check("sb_frame_cnt",  32'(frame_cnt_o),  32'(mx.fcnt));
            check("sb_vtotal",     32'(vtotal_o),     32'(mx.vt));
            check("sb_locked",     32'(locked_o),     32'(mx.locked));
          end
        end
      end
    join_none

    repeat (3) @(posedge VCLK);
    @(negedge VCLK);
    check_all_zero("reset");
    RST = 1'b0;

    // Clean NTSC stream: lock after the second vsync edge
    send_frame(N, 0, 0, -1, -1, 0);
    settle();
    check("t1_unlocked_after_edge1", 32'(locked_o), 0);
    drive_edge(0, 0);
    check("t1_locked_after_edge2", 32'(locked_o), 1);
    send_frame(N, 0, 0, -1, -1, 0);
    send_frame(N, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    @(negedge VCLK);
    check("t1_frame_done_one_cycle", 32'(frame_done_o), 0);
    check("t1_frame_cnt", 32'(frame_cnt_o), 2);
    check("t1_err_cnt",   32'(err_cnt_o),   0);
    check("t1_pass",      32'(frame_pass_o), 1);
    check("t1_htotal",    32'(htotal_o),    L - 1);
    check("t1_vtotal",    32'(vtotal_o),    N - 1);

    // Single blue LSB flip in one frame
    send_frame(N, 0, 0, 6, 12, 0);
    send_frame(N, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    check("t2_err_cnt", 32'(err_cnt_o),    1);
    check("t2_pass",    32'(frame_pass_o), 1);
`ifdef TESTPATTERN_CHECKER_ERRLOG_EN
    check("t2_fe_h", 32'(first_err_h_o), 11);
    check("t2_fe_v", 32'(first_err_v_o), 6);
`endif

    // Roughly half the cycles invalid, with random data on the invalid ones
    for (int k = 0; k < 3; k++) send_frame(N, 0, 0, -1, -1, 50);
    drive_edge(0, 0);
    check("t3_locked",    32'(locked_o),     1);
    check("t3_err_cnt",   32'(err_cnt_o),    1);
    check("t3_frame_cnt", 32'(frame_cnt_o),  7);

    // Geometry change: 14 lines then 15 lines
    send_frame(N, 0, 0, -1, -1, 0);
    send_frame(N + 1, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    check("t4_unlocked", 32'(locked_o), 0);
    check("t4_vtotal",   32'(vtotal_o), N);
    send_frame(N, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    check("t4_align_not_locked", 32'(locked_o), 0);
    send_frame(N, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    check("t4_relocked",   32'(locked_o),  1);
    check("t4_err_clear",  32'(err_cnt_o), 0);
    check_errlog("t4");

    // PAL pattern against NTSC windows, then with matching windows
    send_frame(N, 1, 0, -1, -1, 0);
    send_frame(N, 1, 0, -1, -1, 0);
    drive_edge(1, 0);
    check("t5_pass_bad",  32'(frame_pass_o), 0);
    check("t5_err_cnt",   32'(err_cnt_o),    32'(m_err));
    check_errlog("t5");
    palmode = 1'b1;
    send_frame(N, 1, 0, -1, -1, 0);
    drive_edge(1, 0);
    check("t5_pass_pal",  32'(frame_pass_o), 1);
    palmode = 1'b0;

    // Asynchronous reset mid-line while locked
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < L; j++) begin
        if (i == 0 && j == 0) continue;
        drive_sample(i, j, 0, 0, 1'b0, 0);
      end
    end
    for (int j = 0; j < 7; j++) drive_sample(5, j, 0, 0, 1'b0, 0);
    settle();
    #1 RST = 1'b1;
    #1 check_all_zero("rst_mid");
    model_reset();
    @(negedge VCLK);
    RST = 1'b0;
    send_frame(N, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    check("t6_relocked", 32'(locked_o), 1);
    send_frame(N, 0, 0, -1, -1, 0);
    drive_edge(0, 0);
    check("t6_frame_cnt", 32'(frame_cnt_o), 1);
    check("t6_pass",      32'(frame_pass_o), 1);

    // Every sample wrong for long enough to saturate the error counter
    for (int k = 0; k < 200; k++) send_frame(N, 0, 1, -1, -1, 0);
    drive_edge(0, 1);
    check("t7_err_sat", 32'(err_cnt_o),    32'h0000FFFF);
    check("t7_pass",    32'(frame_pass_o), 0);
    check("t7_locked",  32'(locked_o),     1);
    check_errlog("t7");

    repeat (4) @(negedge VCLK);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
